// File: rtl/rv32imf_instr_aligner.sv
// Realigns prefetch words into whole RV32 instructions (16/32-bit) and tracks their PC.
// A 16-bit residue holds the upper halfword of a fetch word across word boundaries.
module rv32imf_instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_aligned_o,
    output logic [31:0] pc_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);

    typedef enum logic [1:0] {
        ALIGNED,
        MISALIGNED32,
        MISALIGNED16,
        BRANCH_MISALIGNED
    } state_e;

    localparam logic [31:0] RESET_PC    = BOOT_ADDR & ~32'd1;
    localparam state_e      RESET_STATE = BOOT_ADDR[1] ? BRANCH_MISALIGNED : ALIGNED;

    state_e      state_q, state_d;
    logic [15:0] residue_q, residue_d;
    logic [31:0] pc_q, pc_d;

    logic        valid;
    logic        ready;
    logic [31:0] instr;
    state_e      upper_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            residue_q <= '0;
            pc_q      <= RESET_PC;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
            pc_q      <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        residue_d  = residue_q;
        pc_d       = pc_q;
        valid      = 1'b0;
        ready      = 1'b0;
        instr      = '0;
        upper_next = (fetch_rdata_i[17:16] != 2'b11) ? MISALIGNED16 : MISALIGNED32;

        case (state_q)
            ALIGNED: begin
                valid = fetch_valid_i;
                if (fetch_rdata_i[1:0] == 2'b11) begin
                    instr = fetch_rdata_i;
                    if (valid && instr_ready_i) begin
                        ready = 1'b1;
                        pc_d  = pc_q + 32'd4;
                    end
                end else begin
                    instr = {16'h0000, fetch_rdata_i[15:0]};
                    if (valid && instr_ready_i) begin
                        ready     = 1'b1;
                        pc_d      = pc_q + 32'd2;
                        residue_d = fetch_rdata_i[31:16];
                        state_d   = upper_next;
                    end
                end
            end
            MISALIGNED16: begin
                valid = 1'b1;
                instr = {16'h0000, residue_q};
                if (instr_ready_i) begin
                    pc_d    = pc_q + 32'd2;
                    state_d = ALIGNED;
                end
            end
            MISALIGNED32: begin
                valid = fetch_valid_i;
                instr = {fetch_rdata_i[15:0], residue_q};
                if (valid && instr_ready_i) begin
                    ready     = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    residue_d = fetch_rdata_i[31:16];
                    state_d   = upper_next;
                end
            end
            BRANCH_MISALIGNED: begin
                if (fetch_rdata_i[17:16] != 2'b11) begin
                    valid = fetch_valid_i;
                    instr = {16'h0000, fetch_rdata_i[31:16]};
                    if (valid && instr_ready_i) begin
                        ready   = 1'b1;
                        pc_d    = pc_q + 32'd2;
                        state_d = ALIGNED;
                    end
                end else begin
                    // 32-bit target: stash its low half, emit nothing this cycle
                    ready = fetch_valid_i;
                    if (fetch_valid_i) begin
                        residue_d = fetch_rdata_i[31:16];
                        state_d   = MISALIGNED32;
                    end
                end
            end
            default: begin
                state_d = ALIGNED;
            end
        endcase

        if (branch_i) begin
            valid     = 1'b0;
            ready     = 1'b0;
            pc_d      = branch_addr_i & ~32'd1;
            residue_d = '0;
            state_d   = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED;
        end
    end

    assign instr_valid_o   = valid & rst_n;
    assign fetch_ready_o   = ready & rst_n;
    assign instr_aligned_o = rst_n ? instr : '0;
    assign pc_o            = pc_q;

endmodule

// File: tb/tb_rv32imf_instr_aligner.sv
// Self-checking bench for rv32imf_instr_aligner: directed scenarios plus a randomized
// stream checked against a halfword-memory model of the program.
module tb_rv32imf_instr_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_aligned_o;
    logic [31:0] pc_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [2048];

    rv32imf_instr_aligner #(.BOOT_ADDR(32'h0000_0080)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_rdata_i   (fetch_rdata_i),
        .fetch_ready_o   (fetch_ready_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_aligned_o (instr_aligned_o),
        .pc_o            (pc_o),
        .branch_i        (branch_i),
        .branch_addr_i   (branch_addr_i)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hw(input logic [31:0] a);
        return mem[a[11:1]];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        fetch_valid_i = 1'b0; fetch_rdata_i = '0; instr_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0000_0013; instr_ready_i = 1'b1;
        @(negedge clk);
        #1;
        n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
        n_tests++; if (fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", fetch_ready_o); end
        n_tests++; if (instr_aligned_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr_aligned_o); end
        n_tests++; if (pc_o !== 32'h80) begin n_fail++; $display("FAIL rst_pc: got %h want 80", pc_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++; if (instr_aligned_o !== 32'h13) begin n_fail++; $display("FAIL boot_instr: got %h want 13", instr_aligned_o); end
        n_tests++; if (pc_o !== 32'h80) begin n_fail++; $display("FAIL boot_pc: got %h want 80", pc_o); end
        n_tests++; if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL boot_ready: got %b want 1", fetch_ready_o); end
        tick();
        fetch_valid_i = 1'b0;
        #1;
        n_tests++; if (pc_o !== 32'h84) begin n_fail++; $display("FAIL boot_next_pc: got %h want 84", pc_o); end
    endtask

    task automatic test_two_compressed();
        do_reset();
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4505_4501;
        #1;
        n_tests++; if (instr_aligned_o !== 32'h4501 || pc_o !== 32'h80 || fetch_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL two_c_first: got %h@%h rdy %b want 4501@80 rdy 1", instr_aligned_o, pc_o, fetch_ready_o); end
        tick();
        fetch_valid_i = 1'b0;
        #1;
        n_tests++; if (instr_valid_o !== 1'b1 || instr_aligned_o !== 32'h4505 || pc_o !== 32'h82 || fetch_ready_o !== 1'b0)
            begin n_fail++; $display("FAIL two_c_second: got v%b %h@%h rdy %b want v1 4505@82 rdy 0", instr_valid_o, instr_aligned_o, pc_o, fetch_ready_o); end
        tick();
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0000_0013;
        #1;
        n_tests++; if (instr_aligned_o !== 32'h13 || pc_o !== 32'h84)
            begin n_fail++; $display("FAIL two_c_after: got %h@%h want 13@84", instr_aligned_o, pc_o); end
        tick();
    endtask

    task automatic test_straddle();
        do_reset();
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0093_4501;
        #1;
        n_tests++; if (instr_aligned_o !== 32'h4501 || pc_o !== 32'h80)
            begin n_fail++; $display("FAIL straddle_0: got %h@%h want 4501@80", instr_aligned_o, pc_o); end
        tick();
        fetch_rdata_i = 32'h1234_0010;
        #1;
        n_tests++; if (instr_aligned_o !== 32'h0010_0093 || pc_o !== 32'h82 || fetch_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL straddle_1: got %h@%h rdy %b want 00100093@82 rdy 1", instr_aligned_o, pc_o, fetch_ready_o); end
        tick();
        fetch_valid_i = 1'b0;
        #1;
        n_tests++; if (instr_valid_o !== 1'b1 || instr_aligned_o !== 32'h1234 || pc_o !== 32'h86)
            begin n_fail++; $display("FAIL straddle_2: got v%b %h@%h want v1 1234@86", instr_valid_o, instr_aligned_o, pc_o); end
        tick();
    endtask

    task automatic test_branch_misaligned();
        do_reset();
        branch_i = 1'b1; branch_addr_i = 32'h102; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0000_0013;
        #1;
        n_tests++; if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0)
            begin n_fail++; $display("FAIL bmis_branch: got v%b r%b want v0 r0", instr_valid_o, fetch_ready_o); end
        tick();
        branch_i = 1'b0; fetch_rdata_i = 32'h0093_abcd;
        #1;
        n_tests++; if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL bmis_bubble: got v%b r%b want v0 r1", instr_valid_o, fetch_ready_o); end
        tick();
        fetch_rdata_i = 32'h0000_0010;
        #1;
        n_tests++; if (instr_valid_o !== 1'b1 || instr_aligned_o !== 32'h0010_0093 || pc_o !== 32'h102)
            begin n_fail++; $display("FAIL bmis_instr: got v%b %h@%h want v1 00100093@102", instr_valid_o, instr_aligned_o, pc_o); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0093_4501;
        tick();
        fetch_rdata_i = 32'h1234_0010; instr_ready_i = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            #1;
            n_tests++; if (instr_valid_o !== 1'b1 || instr_aligned_o !== 32'h0010_0093 || pc_o !== 32'h82 || fetch_ready_o !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold%0d: got v%b %h@%h r%b want v1 00100093@82 r0", i, instr_valid_o, instr_aligned_o, pc_o, fetch_ready_o); end
            tick();
        end
        instr_ready_i = 1'b1;
        #1;
        n_tests++; if (fetch_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL bp_release: got r%b want r1", fetch_ready_o); end
        tick();
        fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
        #1;
        n_tests++; if (instr_aligned_o !== 32'h1234 || pc_o !== 32'h86)
            begin n_fail++; $display("FAIL bp_once: got %h@%h want 1234@86", instr_aligned_o, pc_o); end
        tick();
        instr_ready_i = 1'b1;
    endtask

    task automatic test_branch_residue();
        do_reset();
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4505_4501;
        tick();
        branch_i = 1'b1; branch_addr_i = 32'h200; fetch_valid_i = 1'b0;
        #1;
        n_tests++; if (instr_valid_o !== 1'b0)
            begin n_fail++; $display("FAIL bres_valid: got %b want 0", instr_valid_o); end
        tick();
        branch_i = 1'b0; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0000_0013;
        #1;
        n_tests++; if (instr_aligned_o !== 32'h13 || pc_o !== 32'h200)
            begin n_fail++; $display("FAIL bres_next: got %h@%h want 13@200", instr_aligned_o, pc_o); end
        tick();
    endtask

    task automatic test_pc_wrap();
        do_reset();
        branch_i = 1'b1; branch_addr_i = 32'hffff_ffff;
        tick();
        branch_i = 1'b0; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4501_0013;
        #1;
        n_tests++; if (instr_aligned_o !== 32'h4501 || pc_o !== 32'hffff_fffe)
            begin n_fail++; $display("FAIL wrap_instr: got %h@%h want 4501@fffffffe", instr_aligned_o, pc_o); end
        tick();
        fetch_valid_i = 1'b0;
        #1;
        n_tests++; if (pc_o !== 32'h0)
            begin n_fail++; $display("FAIL wrap_pc: got %h want 0", pc_o); end
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_pc, fa, tgt, exp_instr;
        logic [15:0] h0;
        logic        br, fresh;
        int          accepts;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 0) mem[i][1:0] = 2'b11;
        end
        do_reset();
        exp_pc = 32'h80; fa = 32'h80; fresh = 1'b0; accepts = 0;
        for (int c = 0; c < 3000; c++) begin
            br  = ($urandom_range(0, 99) < 3);
            tgt = 32'($urandom) & ~32'd1;
            branch_i      = br;
            branch_addr_i = tgt | 32'($urandom_range(0, 1));
            fetch_valid_i = ($urandom_range(0, 3) != 0);
            fetch_rdata_i = {hw(fa + 32'd2), hw(fa)};
            instr_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            h0        = hw(exp_pc);
            exp_instr = (h0[1:0] == 2'b11) ? {hw(exp_pc + 32'd2), h0} : {16'h0000, h0};
            if (br) begin
                n_tests++; if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0)
                    begin n_fail++; $display("FAIL rnd_branch c%0d: got v%b r%b want v0 r0", c, instr_valid_o, fetch_ready_o); end
                exp_pc = tgt; fa = tgt & ~32'd3; fresh = 1'b1;
            end else begin
                if (fetch_ready_o === 1'b1 && fetch_valid_i == 1'b0) begin
                    n_tests++; n_fail++; $display("FAIL rnd_ready c%0d: got ready 1 want 0 with no fetch", c);
                end
                if (instr_valid_o === 1'b1) begin
                    n_tests++; if (instr_aligned_o !== exp_instr || pc_o !== exp_pc)
                        begin n_fail++; $display("FAIL rnd_instr c%0d: got %h@%h want %h@%h", c, instr_aligned_o, pc_o, exp_instr, exp_pc); end
                    if (instr_ready_i) begin
                        exp_pc = exp_pc + ((h0[1:0] == 2'b11) ? 32'd4 : 32'd2);
                        accepts++;
                    end
                end else if (fetch_valid_i && !(fresh && exp_pc[1] && h0[1:0] == 2'b11)) begin
                    n_tests++; n_fail++; $display("FAIL rnd_stall c%0d: got valid 0 want 1 @%h", c, exp_pc);
                end
                if (fetch_ready_o === 1'b1 && fetch_valid_i) begin
                    fa = fa + 32'd4; fresh = 1'b0;
                end
            end
            tick();
        end
        n_tests++; if (accepts < 800)
            begin n_fail++; $display("FAIL rnd_throughput: got %0d transfers want >= 800", accepts); end
        branch_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_compressed();
        test_straddle();
        test_branch_misaligned();
        test_backpressure();
        test_branch_residue();
        test_pc_wrap();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32imf_instr_aligner.md
# rv32imf_instr_aligner

Realigns the 32-bit word stream from the prefetch buffer into whole RV32 instructions (16- or 32-bit) for the ID stage. Its output feeds `rv32imf_compressed_decoder.instr_i`. A 16-bit residue register and a 4-state FSM track halfword alignment across fetch words. The block also keeps the PC of the instruction it presents and reloads it on branches and jumps.

## Interface
- `BOOT_ADDR`, default 32'h0000_0080: PC after reset; bit 0 ignored, bit 1 selects the initial state.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `fetch_valid_i` input 1: the prefetch word on `fetch_rdata_i` is valid.
- `fetch_rdata_i` input 32: word from the prefetch buffer, little-endian halfwords.
- `fetch_ready_o` output 1: the aligner consumes the current fetch word this cycle.
- `instr_valid_o` output 1: `instr_aligned_o` and `pc_o` hold a complete instruction.
- `instr_ready_i` input 1: ID accepts the instruction. A transfer occurs when valid and ready are both high.
- `instr_aligned_o` output 32: the instruction. For compressed instructions bits [31:16] are 16'h0000.
- `pc_o` output 32: address of the instruction on `instr_aligned_o`.
- `branch_i` input 1: redirect request (taken branch, jump, trap). Highest priority.
- `branch_addr_i` input 32: redirect target; bit 0 is treated as 0.

## Operation
- Compressed test: a halfword h is compressed when h[1:0] != 2'b11.
- Registers:
  - `state`: ALIGNED, MISALIGNED32, MISALIGNED16 or BRANCH_MISALIGNED.
  - `residue`: 16 bits.
  - `pc`: 32 bits.
- Notation: F = `fetch_rdata_i`; "accept" = `instr_valid_o & instr_ready_i`.
- **ALIGNED**
  - valid = `fetch_valid_i`.
  - If F[1:0] == 2'b11: output F. On accept: ready = 1, pc += 4, stay in ALIGNED.
  - Else: output {16'h0, F[15:0]}. On accept: ready = 1, pc += 2, residue <= F[31:16].
    - Next state is MISALIGNED16 if F[17:16] != 2'b11, otherwise MISALIGNED32.
- **MISALIGNED16**
  - valid = 1, independent of fetch; output {16'h0, residue}; ready = 0.
  - On accept: pc += 2, go to ALIGNED.
- **MISALIGNED32**
  - valid = `fetch_valid_i`; output {F[15:0], residue}.
  - On accept: ready = 1, pc += 4, residue <= F[31:16].
  - Next state is MISALIGNED16 or MISALIGNED32 by F[17:16], as in ALIGNED.
- **BRANCH_MISALIGNED** (target halfword is the upper half of the fetch word)
  - If F[17:16] != 2'b11: valid = `fetch_valid_i`, output {16'h0, F[31:16]}. On accept: ready = 1, pc += 2, go to ALIGNED.
  - Else: valid = 0, ready = `fetch_valid_i`. When ready is high: residue <= F[31:16], go to MISALIGNED32. This is a one-cycle bubble.
- **branch_i = 1** overrides all of the above that cycle:
  - `instr_valid_o` = 0 and `fetch_ready_o` = 0.
  - Next edge: pc <= {`branch_addr_i`[31:1], 1'b0}, residue <= 0.
  - state <= BRANCH_MISALIGNED if `branch_addr_i`[1], else ALIGNED.
  - The prefetch buffer flushes on the same `branch_i`; the aligner does not consume the stale word.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFE + 2 wraps to 0.
- Reset values:
  - state = ALIGNED, or BRANCH_MISALIGNED if `BOOT_ADDR`[1].
  - pc = {`BOOT_ADDR`[31:1], 1'b0}; residue = 0.
  - While `rst_n` = 0: `instr_valid_o` = 0, `fetch_ready_o` = 0, `instr_aligned_o` = 0, `pc_o` = reset pc.

## Timing
- `instr_aligned_o`, `instr_valid_o`, `fetch_ready_o` and `pc_o` are combinational from the registers and from `fetch_*`, `instr_ready_i` and `branch_i`. There is zero-cycle latency from fetch word to output.
- `fetch_ready_o` may depend on `instr_ready_i`. The prefetch buffer must not make `fetch_valid_i` depend on `fetch_ready_o`.
- Registers update only on accept, on a BRANCH_MISALIGNED 32-bit consume, or on `branch_i`. With `instr_ready_i` = 0, outputs stay stable while `fetch_valid_i` stays high.
- Sustained throughput is one instruction per cycle in every state, except the single bubble after a misaligned branch to a 32-bit instruction.
- Reset asserted mid-stream discards the residue. The first instruction after release comes from `BOOT_ADDR`.

## Test plan
- **Reset, BOOT_ADDR = 32'h80:** `fetch_valid_i` = 1, F = 32'h0000_0013 → `instr_aligned_o` = 32'h0000_0013, `pc_o` = 32'h80. Next pc = 32'h84.
- **Two compressed in one word:** F = 32'h4505_4501 → first output 32'h0000_4501 @ pc 80, `fetch_ready_o` = 1. Second output 32'h0000_4505 @ pc 82 with `fetch_ready_o` = 0 and fetch invalid. Then state ALIGNED, pc 84.
- **Straddling 32-bit:** F0 = 32'h0093_4501, F1 = 32'h1234_0010 → outputs 32'h0000_4501 @ 80, then 32'h0010_0093 @ 82. Residue = 16'h1234 (compressed), so MISALIGNED16 → 32'h0000_1234 @ 86.
- **Misaligned branch to a 32-bit instruction:** `branch_i` to 32'h102, then F = 32'h0093_xxxx, then F = 32'h0000_0010 → one cycle valid = 0 with `fetch_ready_o` = 1, then 32'h0010_0093 @ 102.
- **Backpressure:** hold `instr_ready_i` = 0 for 5 cycles in MISALIGNED32 → outputs and pc unchanged, `fetch_ready_o` = 0. On release, exactly one transfer.
- **Branch during a pending residue:** `branch_i` in MISALIGNED16 to 32'h200 → that cycle valid = 0. The residue is never output; the next instruction comes from 32'h200.
